fifo_memory_v2: RTL
===================

FIFO_MEMORY_V2 -- requirements
Module: fifo_memory_v2

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 4, address width in bits.
REQ-002 SHALL have parameter DATA_SIZE, default 8, word width in bits; a multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 16, number of words; 2 <= DEPTH <= 2**ADDR_SIZE.
REQ-004 SHALL have parameter RD_REG, default 1; 1 = registered read, 0 = asynchronous read.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port clr  input  1  single-cycle request to start a memory clear sweep.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port full  input  1  FIFO full flag; blocks writes.
REQ-010 SHALL have port wr_addr  input  ADDR_SIZE  write address.
REQ-011 SHALL have port wr_be  input  DATA_SIZE/8  byte write enables, bit i covers wr_data[8i+7:8i].
REQ-012 SHALL have port wr_data  input  DATA_SIZE  write data.
REQ-013 SHALL have port rd_en  input  1  read request.
REQ-014 SHALL have port rd_addr  input  ADDR_SIZE  read address.
REQ-015 SHALL have port rd_data  output  DATA_SIZE  read data.
REQ-016 SHALL have port rd_valid  output  1  rd_data qualifier.
REQ-017 SHALL have port busy  output  1  clear sweep in progress; high blocks reads and writes.

Function
REQ-018 SHALL implement a two-state FSM, IDLE and CLEAR, plus a sweep counter of ADDR_SIZE bits.
REQ-019 SHALL transition IDLE -> CLEAR on a rising edge with clr=1, with sweep counter set to 0.
REQ-020 SHALL, in CLEAR, write all-zero to mem[counter] each cycle and increment counter; on the edge that writes address DEPTH-1, return to IDLE.
REQ-021 SHALL ignore clr while in CLEAR; no restart.
REQ-022 SHALL drive busy = 1 exactly while the FSM is in CLEAR; a sweep lasts DEPTH cycles.
REQ-023 SHALL accept a write only when wr_en=1, full=0, busy=0, and wr_addr < DEPTH; it updates only the bytes whose wr_be bit is 1 on the same rising edge.
REQ-024 SHALL drop writes with wr_addr >= DEPTH and never alias them onto valid addresses.
REQ-025 SHALL, for RD_REG=1, accept a read when rd_en=1 and busy=0, load rd_data on the next rising edge, and assert rd_valid for exactly that one cycle.
REQ-026 SHALL, for RD_REG=1, hold rd_data unchanged when no read is accepted.
REQ-027 SHALL, for RD_REG=1 and an accepted read and write to the same address in one cycle, return write-first data: enabled bytes from wr_data, others from the old word.
REQ-028 SHALL, for RD_REG=0, drive rd_data = mem[rd_addr] combinationally and rd_valid = rd_en & ~busy; same-cycle collision returns the old word.
REQ-029 SHALL return all-zero rd_data for an accepted read with rd_addr >= DEPTH; rd_valid behaves as for any accepted read.
REQ-030 SHALL treat wr_be = 0 as an accepted no-op write with no memory change.

Reset
REQ-031 SHALL, on rst assertion, asynchronously force FSM = CLEAR, counter = 0, busy = 1, rd_valid = 0, and registered rd_data = 0.
REQ-032 SHALL NOT reset memory contents in parallel; after rst deasserts, the CLEAR sweep zeroes every word in DEPTH cycles.
REQ-033 SHALL, on rst asserted mid-sweep or mid-read, abort the operation and restart the sweep from address 0.

Verification
REQ-034 Reset then idle (defaults): busy=1 for 16 cycles after rst release, then 0; reading addresses 0..15 returns 0x00 with one-cycle rd_valid pulses.
REQ-035 Byte enables (DATA_SIZE=32): write 0xAABBCCDD with be=4'b1111 to addr 3, then 0x11223344 with be=4'b0101 to addr 3; read addr 3 -> 0xAA22CC44.
REQ-036 Full gating: wr_en=1, full=1, write 0x5A to addr 7; read addr 7 -> 0x00. Repeat with full=0 -> 0x5A.
REQ-037 Collision: RD_REG=1, same-cycle write 0x3C and read to addr 2 holding 0x11 -> rd_data=0x3C next cycle. RD_REG=0, same case -> rd_data=0x11 in that cycle.
REQ-038 Clear sweep: fill all 16 words with 0xFF, pulse clr. Writes and reads during busy are ignored (rd_valid=0). After 16 cycles, all reads return 0x00.
REQ-039 Out-of-range and mid-sweep reset (DEPTH=12, ADDR_SIZE=4): writing addr 13 leaves addrs 0..11 unchanged and reading addr 13 returns 0. Asserting rst at sweep cycle 5 gives busy=1 for a fresh 12 cycles after release.

Source files
------------

// File: rtl/fifo_memory_v2.sv
// fifo_memory_v2: FIFO storage RAM with byte enables, write-first registered read
// or async read, and a DEPTH-cycle zeroing sweep after reset or on request.
module fifo_memory_v2 #(
    parameter int ADDR_SIZE = 4,
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 16,
    parameter int RD_REG    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic                   full,
    input  logic [ADDR_SIZE-1:0]   wr_addr,
    input  logic [DATA_SIZE/8-1:0] wr_be,
    input  logic [DATA_SIZE-1:0]   wr_data,
    input  logic                   rd_en,
    input  logic [ADDR_SIZE-1:0]   rd_addr,
    output logic [DATA_SIZE-1:0]   rd_data,
    output logic                   rd_valid,
    output logic                   busy
);
    localparam int NB = DATA_SIZE / 8;
    localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t               state, state_nx;
    logic [ADDR_SIZE-1:0] cnt, cnt_nx;
    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic                 wr_ok, rd_ok, rd_in;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == IDLE && clr) begin
            state_nx = CLEAR;
            cnt_nx   = '0;
        end else if (state == CLEAR) begin
            cnt_nx = cnt + 1'b1;
            if (cnt == LAST) state_nx = IDLE;
        end
    end

    assign busy  = state == CLEAR;
    assign wr_ok = wr_en && !full && !busy && wr_addr <= LAST;
    assign rd_ok = rd_en && !busy;
    assign rd_in = rd_addr <= LAST;

    // No parallel reset of the array: the sweep owns zeroing while busy
    always_ff @(posedge clk)
        if (busy)
            mem[cnt] <= '0;
        else if (wr_ok)
            for (int i = 0; i < NB; i++)
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];

    if (RD_REG != 0) begin : g_reg
        logic [DATA_SIZE-1:0] word, q;
        logic                 v;
        // Write-first merge so a same-cycle write is visible to the read
        always_comb begin
            word = rd_in ? mem[rd_addr] : '0;
            for (int i = 0; i < NB; i++)
                if (wr_ok && wr_addr == rd_addr && wr_be[i]) word[8*i +: 8] = wr_data[8*i +: 8];
        end
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                q <= '0;
                v <= 1'b0;
            end else begin
                v <= rd_ok;
                if (rd_ok) q <= word;
            end
        assign rd_data  = q;
        assign rd_valid = v;
    end else begin : g_comb
        assign rd_data  = rd_in ? mem[rd_addr] : '0;
        assign rd_valid = rd_ok;
    end
endmodule
